// File: rtl/approx_add_arbiter_if.sv
// Requester/response bundle for approx_add_arbiter.
// req_exact exists only when EXACT_MODE_EN is defined.
interface approx_add_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [16*NREQ-1:0]   req_a;
  logic [16*NREQ-1:0]   req_b;
`ifdef EXACT_MODE_EN
  logic [NREQ-1:0]      req_exact;
`endif
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [15:0]          rsp_sum;
  logic                 rsp_cout;
  logic [15:0]          ops_count;

  modport master (
`ifdef EXACT_MODE_EN
    output req_exact,
`endif
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, ops_count
  );

  modport slave (
`ifdef EXACT_MODE_EN
    input  req_exact,
`endif
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, ops_count
  );
endinterface

// File: rtl/approx_add_arbiter.sv
// Round-robin arbiter feeding a shared 16-bit approximate adder (low byte carry-cut,
// Sklansky upper byte) through a two-stage stallable pipeline. EXACT_MODE_EN adds req_exact.
module approx_add_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  approx_add_arbiter_if.slave       bus
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [IDW-1:0]  ptr_q;
  logic            s1_valid_q;
  logic [15:0]     s1_a_q;
  logic [15:0]     s1_b_q;
  logic [IDW-1:0]  s1_id_q;
`ifdef EXACT_MODE_EN
  logic            s1_exact_q;
`endif
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [15:0]     rsp_sum_q;
  logic            rsp_cout_q;
  logic [15:0]     ops_count_q;

  logic            stall;
  logic            gnt_valid;
  logic [IDW-1:0]  gnt_idx;
  logic [NREQ-1:0] gnt_oh;
  logic [15:0]     sel_a;
  logic [15:0]     sel_b;
`ifdef EXACT_MODE_EN
  logic            sel_exact;
`endif

  logic [15:0]     approx_sum;
  logic            approx_cout;
  logic [15:0]     add_sum;
  logic            add_cout;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] p, input int unsigned off);
    int unsigned s;
    s = 32'(p) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  assign stall = rsp_valid_q & ~bus.rsp_ready;

  // First valid requester after ptr wins; nothing is granted in reset or while stalled.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      if (!gnt_valid && bus.req_valid[rr_idx(ptr_q, off)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = rr_idx(ptr_q, off);
      end
    end
    if (stall || rst) gnt_valid = 1'b0;
  end

  always_comb begin
    gnt_oh = '0;
    if (gnt_valid) gnt_oh[gnt_idx] = 1'b1;
  end

  assign bus.req_ready = gnt_oh;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
`ifdef EXACT_MODE_EN
    sel_exact = 1'b0;
`endif
    for (int r = 0; r < int'(NREQ); r++) begin
      if (gnt_idx == IDW'(r)) begin
        sel_a = bus.req_a[16*r +: 16];
        sel_b = bus.req_b[16*r +: 16];
`ifdef EXACT_MODE_EN
        sel_exact = bus.req_exact[r];
`endif
      end
    end
  end

  // Approximate adder: bits 0..7 take only the neighbour's generate as carry-in;
  // bits 8..15 are a Sklansky prefix tree seeded by c8 = a[7]&b[7].
  logic [7:0] lo_carry;
  logic       c8;
  logic [7:0] hp;
  logic [7:0] gg;
  logic [7:0] pp;
  logic [7:0] hi_carry;

  always_comb begin
    lo_carry = {s1_a_q[6:0] & s1_b_q[6:0], 1'b0};
    c8       = s1_a_q[7] & s1_b_q[7];
    hp       = s1_a_q[15:8] ^ s1_b_q[15:8];
    gg       = s1_a_q[15:8] & s1_b_q[15:8];
    gg[0]    = gg[0] | (hp[0] & c8);
    pp       = hp;
    for (int lvl = 0; lvl < 3; lvl++) begin
      for (int i = 0; i < 8; i++) begin
        if (((i >> lvl) & 1) == 1) begin
          gg[i] = gg[i] | (pp[i] & gg[((i >> lvl) << lvl) - 1]);
          pp[i] = pp[i] & pp[((i >> lvl) << lvl) - 1];
        end
      end
    end
    hi_carry    = {gg[6:0], c8};
    approx_sum  = {hp ^ hi_carry, (s1_a_q[7:0] ^ s1_b_q[7:0]) ^ lo_carry};
    approx_cout = gg[7];
  end

`ifdef EXACT_MODE_EN
  logic [16:0] exact_res;
  assign exact_res = {1'b0, s1_a_q} + {1'b0, s1_b_q};

  always_comb begin
    add_sum  = approx_sum;
    add_cout = approx_cout;
    if (s1_exact_q) begin
      add_sum  = exact_res[15:0];
      add_cout = exact_res[16];
    end
  end
`else
  assign add_sum  = approx_sum;
  assign add_cout = approx_cout;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= IDW'(NREQ - 1);
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
`ifdef EXACT_MODE_EN
      s1_exact_q  <= 1'b0;
`endif
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      ops_count_q <= '0;
    end else begin
      if (!stall) begin
        s1_valid_q  <= gnt_valid;
        s1_a_q      <= sel_a;
        s1_b_q      <= sel_b;
        s1_id_q     <= gnt_idx;
`ifdef EXACT_MODE_EN
        s1_exact_q  <= sel_exact;
`endif
        rsp_valid_q <= s1_valid_q;
        rsp_id_q    <= s1_id_q;
        rsp_sum_q   <= add_sum;
        rsp_cout_q  <= add_cout;
      end
      // A grant always transfers: ready is only raised for a valid requester.
      if (gnt_valid) ptr_q <= gnt_idx;
      if (rsp_valid_q && bus.rsp_ready) ops_count_q <= ops_count_q + 16'd1;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.ops_count = ops_count_q;
endmodule

// File: tb/tb_approx_add_arbiter.sv
// Scoreboard bench for approx_add_arbiter: per-request expected results are queued at issue
// and matched by requester id when responses are accepted.
module tb_approx_add_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = $clog2(NREQ);

  logic clk;
  logic rst;

  approx_add_arbiter_if #(.NREQ(NREQ)) bus ();

  approx_add_arbiter #(.NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int unsigned id;
    logic [16:0] res;
  } sb_t;

  sb_t sb[$];

  int          n_vec;
  int          n_err;
  int unsigned n_since;

  logic        pend_v [NREQ];
  logic [15:0] pend_a [NREQ];
  logic [15:0] pend_b [NREQ];
  logic        pend_x [NREQ];
  logic        rdy;

  int             obs_gnt;
  logic [NREQ-1:0] obs_rdy;
  logic           obs_rv;
  logic [IDW-1:0] obs_id;
  logic [15:0]    obs_sum;
  logic           obs_cout;
  logic [15:0]    obs_ops;
  logic           prev_stall;
  logic [31:0]    prev_snap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: carry into bits 1..7 is the lower neighbour's generate only,
  // the upper byte is an ordinary add with carry-in a[7]&b[7].
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic x);
    logic [15:0] s;
    logic [8:0]  hi;
    logic        ck;
    if (x) return {1'b0, a} + {1'b0, b};
    for (int k = 0; k < 8; k++) begin
      ck   = (k == 0) ? 1'b0 : (a[k-1] & b[k-1]);
      s[k] = a[k] ^ b[k] ^ ck;
    end
    hi = {1'b0, a[15:8]} + {1'b0, b[15:8]} + {8'd0, a[7] & b[7]};
    s[15:8] = hi[7:0];
    return {hi[8], s};
  endfunction

  task automatic issue(input int r, input logic [15:0] a, input logic [15:0] b,
                       input logic x);
    pend_v[r] = 1'b1;
    pend_a[r] = a;
    pend_b[r] = b;
    pend_x[r] = x;
    sb.push_back('{id: r, res: model(a, b, x)});
    n_since++;
  endtask

  // One clock: drive, sample mid-cycle, account transfers/responses, advance to posedge+1.
  task automatic step();
    logic stall;
    int   idx;
    for (int r = 0; r < int'(NREQ); r++) begin
      bus.req_valid[r]        = pend_v[r];
      bus.req_a[16*r +: 16]   = pend_a[r];
      bus.req_b[16*r +: 16]   = pend_b[r];
`ifdef EXACT_MODE_EN
      bus.req_exact[r]        = pend_x[r];
`endif
    end
    bus.rsp_ready = rdy;
    #3;
    obs_rdy  = bus.req_ready;
    obs_rv   = bus.rsp_valid;
    obs_id   = bus.rsp_id;
    obs_sum  = bus.rsp_sum;
    obs_cout = bus.rsp_cout;
    obs_ops  = bus.ops_count;
    obs_gnt  = -1;
    check("ready_legal", 32'(($countones(obs_rdy) <= 1) && ((obs_rdy & ~bus.req_valid) == '0)),
          32'd1);
    for (int r = 0; r < int'(NREQ); r++) begin
      if (obs_rdy[r] && pend_v[r]) begin
        obs_gnt   = r;
        pend_v[r] = 1'b0;
      end
    end
    stall = obs_rv & ~rdy;
    if (stall) begin
      check("stall_ready", 32'(obs_rdy), 32'd0);
      if (prev_stall) check("stall_hold", {12'd0, obs_id, obs_cout, obs_sum}, prev_snap);
    end
    if (obs_rv && rdy) begin
      idx = -1;
      foreach (sb[i]) if (idx < 0 && sb[i].id == 32'(obs_id)) idx = i;
      check("sb_hit", 32'(idx >= 0), 32'd1);
      if (idx >= 0) begin
        check("rsp_data", {15'd0, obs_cout, obs_sum}, {15'd0, sb[idx].res});
        sb.delete(idx);
      end
    end
    prev_stall = stall;
    prev_snap  = {12'd0, obs_id, obs_cout, obs_sum};
    @(posedge clk);
    #1;
  endtask

  task automatic clear_state();
    for (int r = 0; r < int'(NREQ); r++) pend_v[r] = 1'b0;
    sb.delete();
    n_since    = 0;
    prev_stall = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    clear_state();
    rst = 1'b0;
  endtask

  task automatic traffic(input int cycles, input int unsigned cap);
    for (int c = 0; c < cycles; c++) begin
      for (int r = 0; r < int'(NREQ); r++) begin
        if (!pend_v[r] && n_since < cap)
`ifdef EXACT_MODE_EN
          issue(r, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
`else
          issue(r, 16'($urandom), 16'($urandom), 1'b0);
`endif
      end
      if (n_since >= cap && !pend_v[0] && !pend_v[1] && !pend_v[2] && !pend_v[3]) break;
      step();
    end
  endtask

  task automatic drain();
    rdy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (sb.size() == 0) break;
      step();
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    check("ops_count", 32'(bus.ops_count), 32'(n_since[15:0]));
  endtask

  task automatic single(input int r, input logic [15:0] a, input logic [15:0] b, input logic x,
                        input logic [15:0] esum, input logic ecout);
    issue(r, a, b, x);
    step();
    check("single_gnt", 32'(obs_gnt), 32'(r));
    step();
    check("lat_early", 32'(obs_rv), 32'd0);
    step();
    check("lat_valid", 32'(obs_rv), 32'd1);
    check("single_id", 32'(obs_id), 32'(r));
    check("single_sum", 32'(obs_sum), 32'(esum));
    check("single_cout", 32'(obs_cout), 32'(ecout));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rdy   = 1'b1;
    clear_state();
    for (int r = 0; r < int'(NREQ); r++) begin
      pend_a[r] = '0;
      pend_b[r] = '0;
      pend_x[r] = 1'b0;
    end

    // Reset state, with every requester asking.
    rst = 1'b1;
    for (int r = 0; r < int'(NREQ); r++) issue(r, 16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    #1;
    step();
    step();
    check("rst_ready", 32'(obs_rdy), 32'd0);
    check("rst_rv", 32'(obs_rv), 32'd0);
    check("rst_id", 32'(obs_id), 32'd0);
    check("rst_sum", 32'(obs_sum), 32'd0);
    check("rst_cout", 32'(obs_cout), 32'd0);
    check("rst_ops", 32'(obs_ops), 32'd0);
    clear_state();
    rst = 1'b0;

    single(2, 16'h00FF, 16'h0001, 1'b0, 16'h00FC, 1'b0);
    single(1, 16'h0FF0, 16'h0010, 1'b0, 16'h0FC0, 1'b0);
    single(3, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    single(0, 16'h0080, 16'h0080, 1'b0, 16'h0100, 1'b0);
`ifdef EXACT_MODE_EN
    single(2, 16'h00FF, 16'h0001, 1'b1, 16'h0100, 1'b0);
`endif
    drain();

    // Round robin with every requester continuously valid.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      traffic(1, 32'hFFFF_FFFF);
      check("rr_gnt", 32'(obs_gnt), 32'(k % 4));
      if (k >= 2) begin
        check("rr_valid", 32'(obs_rv), 32'd1);
        check("rr_id", 32'(obs_id), 32'((k - 2) % 4));
      end
    end
    drain();

    // Backpressure for 5 cycles in the middle of traffic.
    traffic(4, 32'hFFFF_FFFF);
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      traffic(1, 32'hFFFF_FFFF);
      check("bp_ready", 32'(obs_rdy), 32'd0);
      check("bp_gnt", 32'(obs_gnt), 32'hFFFF_FFFF);
    end
    rdy = 1'b1;
    traffic(6, 32'hFFFF_FFFF);
    drain();

    // Reset with both stages full.
    traffic(4, 32'hFFFF_FFFF);
    rst = 1'b1;
    step();
    check("mid_rst_ready", 32'(obs_rdy), 32'd0);
    clear_state();
    rst = 1'b0;
    traffic(1, 32'hFFFF_FFFF);
    check("mid_rst_rv", 32'(obs_rv), 32'd0);
    check("mid_rst_ops", 32'(obs_ops), 32'd0);
    check("mid_rst_gnt", 32'(obs_gnt), 32'd0);
    traffic(1, 32'hFFFF_FFFF);
    check("mid_rst_flush", 32'(obs_rv), 32'd0);
    check("mid_rst_gnt2", 32'(obs_gnt), 32'd1);
    drain();

    // ops_count wrap.
    do_reset();
    traffic(66000, 32'd65535);
    drain();
    check("ops_ffff", 32'(bus.ops_count), 32'h0000_FFFF);
    issue(1, 16'h1234, 16'h4321, 1'b0);
    drain();
    check("ops_wrap", 32'(bus.ops_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
